// File: rtl/code_lock_fsm.sv
// Code lock: debounced release events on NBTN buttons are matched against CODE; 7-segment LED shows progress/result.
// Define CODE_LOCK_LOCKOUT_EN to add the fail counter and the timed LOCK state.
module code_lock_fsm #(
    parameter int NBTN = 2,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*$clog2(NBTN)-1:0] CODE = 4'b1001,
    parameter int TICK_DIV = 256,
    parameter int DEB_LEN = 16,
    parameter int RESULT_TICKS = 7200,
    parameter int MAX_FAIL = 3,
    parameter int LOCK_TICKS = 28800
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] button,
    output logic [7:0]      LED,
    output logic            unlocked,
    output logic            locked_out
);

    localparam int BW   = $clog2(NBTN);
    localparam int DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW   = $clog2(DEB_LEN + 1);
    localparam int TMAX = (RESULT_TICKS > LOCK_TICKS) ? RESULT_TICKS : LOCK_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    // Valid/ready is not used here: button releases are single-tick events consumed in the cycle they occur.
    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_OK    = 2'd1,
        S_FAIL  = 2'd2
`ifdef CODE_LOCK_LOCKOUT_EN
        , S_LOCK = 2'd3
`endif
    } state_t;

    logic [DW-1:0]   div_q;
    logic            tick;
    logic [NBTN-1:0] sync1_q, sync2_q, deb_q, rise;
    logic [CW-1:0]   deb_cnt_q [NBTN];

    state_t          state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic            mis_q, mis_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [2:0]      n_press;
    logic [BW-1:0]   press_idx, exp_idx;
    logic            any_press, bad_press;
    logic [7:0]      led_d;
    logic            unl_d;

    assign tick = (div_q == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            for (int i = 0; i < NBTN; i++) deb_cnt_q[i] <= '0;
        end else begin
            div_q   <= tick ? '0 : div_q + 1'b1;
            sync1_q <= button;
            sync2_q <= sync1_q;
            if (tick) begin
                for (int i = 0; i < NBTN; i++) begin
                    if (sync2_q[i] != deb_q[i]) begin
                        if (deb_cnt_q[i] == CW'(DEB_LEN - 1)) begin
                            deb_q[i]     <= sync2_q[i];
                            deb_cnt_q[i] <= '0;
                        end else begin
                            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                        end
                    end else begin
                        deb_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    // A release event fires on the tick the debounced level flips from low to high.
    always_comb begin
        rise      = '0;
        n_press   = '0;
        press_idx = '0;
        for (int i = 0; i < NBTN; i++) begin
            rise[i] = tick && !deb_q[i] && sync2_q[i] && (deb_cnt_q[i] == CW'(DEB_LEN - 1));
            if (rise[i]) begin
                n_press   = n_press + 3'd1;
                press_idx = BW'(i);
            end
        end
        exp_idx   = BW'(CODE >> (int'(k_q) * BW));
        any_press = (n_press != 3'd0);
        bad_press = (n_press > 3'd1) || (press_idx != exp_idx);
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [FW-1:0] fail_q, fail_d;
    logic          lo_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ENTRY;
            k_q     <= '0;
            mis_q   <= 1'b0;
            tmr_q   <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mis_q   <= mis_d;
            tmr_q   <= tmr_d;
`ifdef CODE_LOCK_LOCKOUT_EN
            fail_q  <= fail_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mis_d   = mis_q;
        tmr_d   = tmr_q;
`ifdef CODE_LOCK_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        case (state_q)
            S_ENTRY: begin
                if (k_q >= 4'(CODE_LEN)) begin
                    k_d   = '0;
                    mis_d = 1'b0;
                end else if (any_press) begin
                    if (k_q == 4'(CODE_LEN - 1)) begin
                        k_d   = '0;
                        mis_d = 1'b0;
                        tmr_d = '0;
                        if (mis_q || bad_press) begin
                            state_d = S_FAIL;
`ifdef CODE_LOCK_LOCKOUT_EN
                            fail_d  = fail_q + 1'b1;
`endif
                        end else begin
                            state_d = S_OK;
`ifdef CODE_LOCK_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end
                    end else begin
                        k_d   = k_q + 4'd1;
                        mis_d = mis_q | bad_press;
                    end
                end
            end
            S_OK: begin
                if (tick) begin
                    if (tmr_q == TW'(RESULT_TICKS - 1)) begin
                        state_d = S_ENTRY;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_FAIL: begin
                if (tick) begin
                    if (tmr_q == TW'(RESULT_TICKS - 1)) begin
                        tmr_d   = '0;
                        state_d = S_ENTRY;
`ifdef CODE_LOCK_LOCKOUT_EN
                        if (fail_q >= FW'(MAX_FAIL)) state_d = S_LOCK;
`endif
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
`ifdef CODE_LOCK_LOCKOUT_EN
            S_LOCK: begin
                if (tick) begin
                    if (tmr_q == TW'(LOCK_TICKS - 1)) begin
                        state_d = S_ENTRY;
                        tmr_d   = '0;
                        fail_d  = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_ENTRY;
                k_d     = '0;
                mis_d   = 1'b0;
                tmr_d   = '0;
            end
        endcase
    end

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 8'h03;
            4'd1: seg = 8'h9F;
            4'd2: seg = 8'h25;
            4'd3: seg = 8'h0D;
            4'd4: seg = 8'h99;
            4'd5: seg = 8'h49;
            4'd6: seg = 8'h41;
            4'd7: seg = 8'h1F;
            4'd8: seg = 8'h01;
            4'd9: seg = 8'h09;
            default: seg = 8'hFF;
        endcase
    endfunction

    always_comb begin
        led_d = 8'h03;
        unl_d = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
        lo_d  = 1'b0;
`endif
        case (state_q)
            S_ENTRY: led_d = seg(k_q);
            S_OK: begin
                led_d = 8'h00;
                unl_d = 1'b1;
            end
            S_FAIL: led_d = 8'h91;
`ifdef CODE_LOCK_LOCKOUT_EN
            S_LOCK: begin
                led_d = 8'hFE;
                lo_d  = 1'b1;
            end
`endif
            default: led_d = 8'h03;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LED      <= 8'h03;
            unlocked <= 1'b0;
        end else begin
            LED      <= led_d;
            unlocked <= unl_d;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) locked_out <= 1'b0;
        else        locked_out <= lo_d;
    end
`else
    assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: directed scenarios then random code attempts, checked against a press-sequence model.
module tb_code_lock_fsm;
    localparam int NBTN = 2;
    localparam int CODE_LEN = 4;
    localparam int TICK_DIV = 4;
    localparam int DEB_LEN = 2;
    localparam int RESULT_TICKS = 8;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_TICKS = 16;
    localparam int RES_CLKS = RESULT_TICKS * TICK_DIV;
    localparam int LOCK_CLKS = LOCK_TICKS * TICK_DIV;
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NBTN-1:0] button = '1;
    logic [7:0]      LED;
    logic            unlocked;
    logic            locked_out;

    code_lock_fsm #(
        .NBTN(NBTN), .CODE_LEN(CODE_LEN), .CODE(4'b1001), .TICK_DIV(TICK_DIV),
        .DEB_LEN(DEB_LEN), .RESULT_TICKS(RESULT_TICKS), .MAX_FAIL(MAX_FAIL), .LOCK_TICKS(LOCK_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .button(button),
        .LED(LED), .unlocked(unlocked), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         code_arr [CODE_LEN] = '{1, 0, 0, 1};
    logic [7:0] seg_tbl [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    logic [7:0] exp_q [$];
    int         entries = 0;
    int         fail_cnt = 0;
    bit         mism = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        entries  = 0;
        mism     = 1'b0;
        fail_cnt = 0;
        exp_q.delete();
    endtask

    // mask bit set = that button is held down, then all are released together.
    task automatic press_btn(input logic [1:0] mask);
        @(posedge clk);
        #1 button = ~mask;
        repeat (TICK_DIV * $urandom_range(4, 6)) @(posedge clk);
        #1 button = '1;
        if (mask != (2'b01 << code_arr[entries])) mism = 1'b1;
        entries++;
    endtask

    task automatic glitch(input int b);
        @(posedge clk);
        #1 button[b] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 button[b] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag);
        exp_q.push_back(seg_tbl[entries]);
        repeat (24) @(negedge clk);
        check(tag, 32'(LED), 32'(exp_q.pop_front()));
        check({tag, "_unl"}, 32'(unlocked), 32'd0);
    endtask

    // Watches the whole result (and possible lockout) period after the final press, poking buttons that must be ignored.
    task automatic watch_result(input string tag);
        bit ok, lock;
        int n00, n91, nfe, nunl, nlo;
        ok = !mism;
        if (ok) fail_cnt = 0;
        else    fail_cnt++;
        lock = LOCK_EN && !ok && (fail_cnt >= MAX_FAIL);
        if (lock) fail_cnt = 0;
        entries = 0;
        mism = 1'b0;
        n00 = 0; n91 = 0; nfe = 0; nunl = 0; nlo = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (c == 10) button = 2'($urandom_range(0, 2));
            if (c == 20) button = '1;
            if (lock && c == 60) button = 2'b10;
            if (lock && c == 75) button = '1;
            if (LED == 8'h00) n00++;
            if (LED == 8'h91) n91++;
            if (LED == 8'hFE) nfe++;
            if (unlocked) nunl++;
            if (locked_out) nlo++;
        end
        check({tag, "_ok_clks"}, 32'(n00), ok ? 32'(RES_CLKS) : 32'd0);
        check({tag, "_fail_clks"}, 32'(n91), ok ? 32'd0 : 32'(RES_CLKS));
        check({tag, "_lock_clks"}, 32'(nfe), lock ? 32'(LOCK_CLKS) : 32'd0);
        check({tag, "_unl_clks"}, 32'(nunl), ok ? 32'(RES_CLKS) : 32'd0);
        check({tag, "_lo_clks"}, 32'(nlo), lock ? 32'(LOCK_CLKS) : 32'd0);
        check({tag, "_end_led"}, 32'(LED), 32'h03);
    endtask

    task automatic enter_code(input string tag, input logic [1:0] m0, input logic [1:0] m1,
                              input logic [1:0] m2, input logic [1:0] m3);
        press_btn(m0); check_entry({tag, "_e1"});
        press_btn(m1); check_entry({tag, "_e2"});
        press_btn(m2); check_entry({tag, "_e3"});
        press_btn(m3); watch_result(tag);
    endtask

    function automatic logic [1:0] rand_mask(input int k);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7)       rand_mask = 2'b01 << code_arr[k];
        else if (r < 9)  rand_mask = 2'b01 << (1 - code_arr[k]);
        else             rand_mask = 2'b11;
    endfunction

    initial begin
        logic [1:0] m [CODE_LEN];
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_led", 32'(LED), 32'h03);
        check("rst_unl", 32'(unlocked), 32'd0);
        check("rst_lo", 32'(locked_out), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_led", 32'(LED), 32'h03);

        enter_code("good", 2'b10, 2'b01, 2'b01, 2'b10);
        enter_code("bad_first", 2'b01, 2'b01, 2'b01, 2'b10);

        for (int g = 0; g < 3; g++) glitch(1);
        repeat (8) @(negedge clk);
        check("bounce_none", 32'(LED), 32'h03);
        enter_code("bounce", 2'b10, 2'b01, 2'b01, 2'b10);

        enter_code("both", 2'b11, 2'b01, 2'b01, 2'b10);

        press_btn(2'b10); check_entry("rst_mid_e1");
        press_btn(2'b01); check_entry("rst_mid_e2");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_led", 32'(LED), 32'h03);
        check("rst_mid_unl", 32'(unlocked), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_rel_led", 32'(LED), 32'h03);
        enter_code("after_rst", 2'b10, 2'b01, 2'b01, 2'b10);

        for (int a = 0; a < 3; a++) enter_code("wrong3", 2'b01, 2'b01, 2'b01, 2'b10);

        press_btn(2'b10); check_entry("rst_res_e1");
        press_btn(2'b01); check_entry("rst_res_e2");
        press_btn(2'b01); check_entry("rst_res_e3");
        press_btn(2'b10);
        repeat (24) @(negedge clk);
        check("rst_res_ok_led", 32'(LED), 32'h00);
        check("rst_res_ok_unl", 32'(unlocked), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_res_led", 32'(LED), 32'h03);
        check("rst_res_unl", 32'(unlocked), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_res_rel", 32'(LED), 32'h03);

        for (int a = 0; a < 12; a++) begin
            for (int k = 0; k < CODE_LEN; k++) m[k] = rand_mask(k);
            if ($urandom_range(0, 2) == 0) glitch(int'($urandom_range(0, 1)));
            enter_code("rand", m[0], m[1], m[2], m[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/code_lock_fsm.md
CODE_LOCK_FSM -- requirements
Module: code_lock_fsm

Interface
REQ-001 The block SHALL have parameter NBTN, default 2: number of entry buttons, range 2..4.
REQ-002 The block SHALL have parameter CODE_LEN, default 4: number of presses per code, range 1..9.
REQ-003 The block SHALL have parameter CODE, default {1,0,0,1} (entry 0 in the LSBs): CODE_LEN fields of clog2(NBTN) bits; field k is the button index expected at press k.
REQ-004 The block SHALL have parameter TICK_DIV, default 256: clk cycles per internal tick.
REQ-005 The block SHALL have parameter DEB_LEN, default 16: consecutive equal samples needed to change debounced level.
REQ-006 The block SHALL have parameter RESULT_TICKS, default 7200: ticks for which the OK or FAIL result is shown.
REQ-007 The block SHALL have parameter MAX_FAIL, default 3, and parameter LOCK_TICKS, default 28800; both are used only under LOCKOUT_EN.
REQ-008 The block SHALL have port clk, input, 1 bit: single clock.
REQ-009 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 The block SHALL have port button, input, NBTN bits: raw active-low pushbuttons, asynchronous to clk.
REQ-011 The block SHALL have port LED, output, 8 bits: active-low 7-segment pattern {a..g,dp}.
REQ-012 The block SHALL have port unlocked, output, 1 bit: high while in state OK.
REQ-013 The block SHALL have port locked_out, output, 1 bit: high while in state LOCK (tied low without LOCKOUT_EN).

Function
REQ-014 The tick SHALL be a one-clk enable asserted every TICK_DIV clk cycles from a free-running counter; all debouncing and FSM timing SHALL advance only on tick, with no derived clocks.
REQ-015 Each button SHALL be synchronised through two flops, then debounced: the debounced level flips after DEB_LEN consecutive tick samples differ from the current level.
REQ-016 A press event for button i SHALL be a debounced low-to-high (release) transition, lasting one tick.
REQ-017 If press events for two or more buttons occur on the same tick, the entry SHALL be recorded as a mismatch.
REQ-018 FSM states SHALL be ENTRY(k, k=0..CODE_LEN-1), OK, FAIL, and LOCK.
REQ-019 In ENTRY(k), a press SHALL increment k and set a sticky mismatch flag if the index differs from CODE field k.
REQ-020 The press that completes CODE_LEN entries SHALL move the FSM to OK if the mismatch flag is clear, otherwise to FAIL; no early fail SHALL occur.
REQ-021 OK and FAIL SHALL each hold for exactly RESULT_TICKS ticks, then go to ENTRY(0) with the mismatch flag cleared; presses during OK, FAIL or LOCK SHALL be ignored.
REQ-022 LED SHALL be as follows: ENTRY(k) shows digit k (0=03,1=9F,2=25,3=0D,4=99,5=49,6=41,7=1F,8=01,9=09 hex); OK shows 00; FAIL shows 91; LOCK shows FE.
REQ-023 LED, unlocked and locked_out SHALL be registered and SHALL change on the clk edge after the state change.
REQ-024 Any out-of-range state SHALL recover to ENTRY(0).

Reset
REQ-025 Reset low SHALL asynchronously force: state to ENTRY(0), mismatch clear, all counters to 0, debounced levels to high (released), LED to 03, unlocked to 0, locked_out to 0.
REQ-026 Reset asserted mid-entry or mid-result SHALL discard all progress; no press event SHALL be generated by reset release.

Configuration
REQ-027 With macro CODE_LOCK_LOCKOUT_EN defined, a fail counter SHALL increment on each entry into FAIL and clear on entry into OK.
REQ-028 With CODE_LOCK_LOCKOUT_EN defined, when the counter reaches MAX_FAIL, the FAIL period SHALL end in LOCK instead of ENTRY(0).
REQ-029 With CODE_LOCK_LOCKOUT_EN defined, LOCK SHALL hold for LOCK_TICKS ticks, then go to ENTRY(0) and clear the counter.
REQ-030 Without CODE_LOCK_LOCKOUT_EN, no fail counter and no LOCK state SHALL exist, and locked_out SHALL be constant 0.

Verification
REQ-031 Bench parameters SHALL be TICK_DIV=4, DEB_LEN=2, RESULT_TICKS=8, LOCK_TICKS=16, MAX_FAIL=3, with default CODE.
REQ-032 Correct sequence B1,B0,B0,B1 -> LED steps 03,9F,25,0D, then 00 with unlocked=1 for 8 ticks, then 03.
REQ-033 Sequence B0,B0,B0,B1 -> no early fail, LED reaches 0D, then 91 for 8 ticks, unlocked=0, then 03.
REQ-034 Bounce of 1-tick glitches on B1 followed by a clean press -> exactly one press event, LED 03 -> 9F.
REQ-035 B0 and B1 released on the same tick as entry 0 -> counted as a mismatch; after 3 further presses, FAIL.
REQ-036 Reset pulled low after 2 correct presses -> LED=03 immediately (asynchronously); a fresh correct code then succeeds.
REQ-037 With LOCKOUT_EN defined, 3 wrong codes -> third FAIL, then LOCK with LED=FE and locked_out=1 for 16 ticks, with presses ignored; without LOCKOUT_EN, the same stimulus returns to 03 after each FAIL.
